// File: rtl/lowentropy_codebook_pkg.sv
// Shared types and sizing for the low-entropy codebook engine.
// The sizing localparams here are the single configuration point for the
// engine and its CAM sub-module.
package lowentropy_codebook_pkg;

  localparam int NUM_CODES   = 16;
  localparam int SYM_W       = 4;
  localparam int PREFIX_MAX  = 16;
  localparam int CW_W        = 21;
  localparam int LEN_W       = 6;
  localparam int TABLE_DEPTH = 256;

  localparam int AP_W   = PREFIX_MAX * SYM_W;
  localparam int CODE_W = $clog2(NUM_CODES);
  localparam int ADDR_W = $clog2(TABLE_DEPTH);

  localparam logic [SYM_W-1:0] ESC_SYM = SYM_W'('hF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MATCH,
    ST_EMIT,
    ST_FSCAN,
    ST_FMATCH,
    ST_FEMIT
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              flush;
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  cnt;
    logic [AP_W-1:0]   data;
    logic [CW_W-1:0]   cw;
    logic [LEN_W-1:0]  len;
  } entry_t;

  // Shift a symbol into the LSBs of a prefix; the oldest symbol falls off the top.
  function automatic logic [AP_W-1:0] append_sym(input logic [AP_W-1:0] data,
                                                 input logic [SYM_W-1:0] sym);
    return {data[AP_W-SYM_W-1:0], sym};
  endfunction

endpackage

// File: rtl/lowentropy_codebook_engine_cam_match.sv
// Combinational parallel compare of a prefix key against every codebook
// entry, followed by a lowest-index-wins priority encoder.
module codebook_cam_match
  import lowentropy_codebook_pkg::*;
(
  input  entry_t            entries [TABLE_DEPTH],
  input  logic              key_flush,
  input  logic [CODE_W-1:0] key_code,
  input  logic [LEN_W-1:0]  key_cnt,
  input  logic [AP_W-1:0]   key_data,
  output logic              hit,
  output logic [CW_W-1:0]   cw,
  output logic [LEN_W-1:0]  len
);

  logic [TABLE_DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < TABLE_DEPTH; gi++) begin : g_cmp
      assign match[gi] = entries[gi].valid
                       && (entries[gi].flush == key_flush)
                       && (entries[gi].code  == key_code)
                       && (entries[gi].cnt   == key_cnt)
                       && (entries[gi].data  == key_data);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the last to assign.
  always_comb begin
    hit = 1'b0;
    cw  = '0;
    len = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        cw  = entries[i].cw;
        len = entries[i].len;
      end
    end
  end

endmodule

// File: rtl/lowentropy_codebook_engine.sv
// Table-driven low-entropy code engine: keeps one active prefix per code,
// emits a codeword when a prefix matches a programmed entry, and flushes
// all non-empty prefixes on request.
// Optional statistics counters: define LE_CODEBOOK_STATS_EN.
module lowentropy_codebook_engine
  import lowentropy_codebook_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cfg_we_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic              cfg_valid_i,
  input  logic              cfg_flush_i,
  input  logic [CODE_W-1:0] cfg_code_i,
  input  logic [LEN_W-1:0]  cfg_cnt_i,
  input  logic [AP_W-1:0]   cfg_data_i,
  input  logic [CW_W-1:0]   cfg_cw_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic              sym_valid_i,
  output logic              sym_ready_o,
  input  logic [CODE_W-1:0] sym_code_i,
  input  logic [SYM_W-1:0]  sym_data_i,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              cw_valid_o,
  input  logic              cw_ready_i,
  output logic [CW_W-1:0]   cw_data_o,
  output logic [LEN_W-1:0]  cw_len_o,
  output logic [CODE_W-1:0] cw_code_o,
  output logic              cw_flush_o,
  output logic              err_o,
  output logic              busy_o
`ifdef LE_CODEBOOK_STATS_EN
  ,
  output logic [31:0]       stat_cw_cnt_o,
  output logic [15:0]       stat_err_cnt_o
`endif
);

  state_t            state_reg;
  logic [CODE_W-1:0] scan_idx_reg;
  logic [LEN_W-1:0]  ap_cnt_reg  [NUM_CODES];
  logic [AP_W-1:0]   ap_data_reg [NUM_CODES];

  logic              key_flush_reg;
  logic [CODE_W-1:0] key_code_reg;
  logic [LEN_W-1:0]  key_cnt_reg;
  logic [AP_W-1:0]   key_data_reg;

  logic              cw_valid_reg;
  logic [CW_W-1:0]   cw_data_reg;
  logic [LEN_W-1:0]  cw_len_reg;
  logic [CODE_W-1:0] cw_code_reg;
  logic              cw_flush_reg;
  logic              err_reg;
  logic              done_reg;

  entry_t            table_reg [TABLE_DEPTH];
  entry_t            cfg_entry;

  logic              hit;
  logic [CW_W-1:0]   hit_cw;
  logic [LEN_W-1:0]  hit_len;
  logic              busy;
  logic              scan_last;

  assign busy      = (state_reg != ST_IDLE);
  assign scan_last = (scan_idx_reg == CODE_W'(NUM_CODES - 1));

  // Pack the configuration inputs into one table entry.
  always_comb begin
    cfg_entry       = '0;
    cfg_entry.valid = cfg_valid_i;
    cfg_entry.flush = cfg_flush_i;
    cfg_entry.code  = cfg_code_i;
    cfg_entry.cnt   = cfg_cnt_i;
    cfg_entry.data  = cfg_data_i;
    cfg_entry.cw    = cfg_cw_i;
    cfg_entry.len   = cfg_len_i;
  end

  // Codebook table: only valid bits are reset; writes while busy are dropped
  // so the CAM never sees the table change under an in-flight lookup.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        table_reg[i].valid <= 1'b0;
      end
    end else if (cfg_we_i && !busy) begin
      table_reg[cfg_addr_i] <= cfg_entry;
    end
  end

  codebook_cam_match u_cam (
    .entries   (table_reg),
    .key_flush (key_flush_reg),
    .key_code  (key_code_reg),
    .key_cnt   (key_cnt_reg),
    .key_data  (key_data_reg),
    .hit       (hit),
    .cw        (hit_cw),
    .len       (hit_len)
  );

  // Main FSM: symbol lookup path plus the flush scan, with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      scan_idx_reg  <= '0;
      key_flush_reg <= 1'b0;
      key_code_reg  <= '0;
      key_cnt_reg   <= '0;
      key_data_reg  <= '0;
      cw_valid_reg  <= 1'b0;
      cw_data_reg   <= '0;
      cw_len_reg    <= '0;
      cw_code_reg   <= '0;
      cw_flush_reg  <= 1'b0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
      for (int i = 0; i < NUM_CODES; i++) begin
        ap_cnt_reg[i]  <= '0;
        ap_data_reg[i] <= '0;
      end
    end else begin
      err_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (flush_i) begin
            scan_idx_reg <= '0;
            state_reg    <= ST_FSCAN;
          end else if (sym_valid_i) begin
            key_flush_reg <= 1'b0;
            key_code_reg  <= sym_code_i;
            key_cnt_reg   <= ap_cnt_reg[sym_code_i] + LEN_W'(1);
            key_data_reg  <= append_sym(ap_data_reg[sym_code_i], sym_data_i);
            state_reg     <= ST_MATCH;
          end
        end
        ST_MATCH: begin
          if (hit) begin
            cw_valid_reg               <= 1'b1;
            cw_data_reg                <= hit_cw;
            cw_len_reg                 <= hit_len;
            cw_code_reg                <= key_code_reg;
            cw_flush_reg               <= 1'b0;
            ap_cnt_reg[key_code_reg]   <= '0;
            ap_data_reg[key_code_reg]  <= '0;
            state_reg                  <= ST_EMIT;
          end else if (key_cnt_reg == LEN_W'(PREFIX_MAX)) begin
            // Prefix cannot grow further: report and start over.
            err_reg                    <= 1'b1;
            ap_cnt_reg[key_code_reg]   <= '0;
            ap_data_reg[key_code_reg]  <= '0;
            state_reg                  <= ST_IDLE;
          end else begin
            ap_cnt_reg[key_code_reg]   <= key_cnt_reg;
            ap_data_reg[key_code_reg]  <= key_data_reg;
            state_reg                  <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (cw_ready_i) begin
            cw_valid_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        ST_FSCAN: begin
          if (ap_cnt_reg[scan_idx_reg] == '0) begin
            if (scan_last) begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              scan_idx_reg <= scan_idx_reg + CODE_W'(1);
            end
          end else begin
            key_flush_reg <= 1'b1;
            key_code_reg  <= scan_idx_reg;
            key_cnt_reg   <= ap_cnt_reg[scan_idx_reg];
            key_data_reg  <= ap_data_reg[scan_idx_reg];
            state_reg     <= ST_FMATCH;
          end
        end
        ST_FMATCH: begin
          ap_cnt_reg[key_code_reg]  <= '0;
          ap_data_reg[key_code_reg] <= '0;
          if (hit) begin
            cw_valid_reg <= 1'b1;
            cw_data_reg  <= hit_cw;
            cw_len_reg   <= hit_len;
            cw_code_reg  <= key_code_reg;
            cw_flush_reg <= 1'b1;
            state_reg    <= ST_FEMIT;
          end else begin
            // The prefix is now empty, so the next scan cycle moves past it.
            err_reg   <= 1'b1;
            state_reg <= ST_FSCAN;
          end
        end
        ST_FEMIT: begin
          if (cw_ready_i) begin
            cw_valid_reg <= 1'b0;
            // On the last code, stay put: the emptied prefix ends the scan.
            if (!scan_last) begin
              scan_idx_reg <= scan_idx_reg + CODE_W'(1);
            end
            state_reg <= ST_FSCAN;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sym_ready_o  = (state_reg == ST_IDLE) && !flush_i;
  assign busy_o       = busy;
  assign cw_valid_o   = cw_valid_reg;
  assign cw_data_o    = cw_data_reg;
  assign cw_len_o     = cw_len_reg;
  assign cw_code_o    = cw_code_reg;
  assign cw_flush_o   = cw_flush_reg;
  assign err_o        = err_reg;
  assign flush_done_o = done_reg;

`ifdef LE_CODEBOOK_STATS_EN
  logic [31:0] stat_cw_reg;
  logic [15:0] stat_err_reg;

  // Handshake counter wraps; error counter saturates at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stat_cw_reg  <= '0;
      stat_err_reg <= '0;
    end else begin
      if (cw_valid_reg && cw_ready_i) begin
        stat_cw_reg <= stat_cw_reg + 32'd1;
      end
      if (err_reg && (stat_err_reg != 16'hFFFF)) begin
        stat_err_reg <= stat_err_reg + 16'd1;
      end
    end
  end

  assign stat_cw_cnt_o  = stat_cw_reg;
  assign stat_err_cnt_o = stat_err_reg;
`endif

endmodule

// File: tb/tb_lowentropy_codebook_engine.sv
// Directed testbench for lowentropy_codebook_engine with hand-computed expectations.
module tb_lowentropy_codebook_engine;
  import lowentropy_codebook_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              cfg_we_i;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic              cfg_valid_i;
  logic              cfg_flush_i;
  logic [CODE_W-1:0] cfg_code_i;
  logic [LEN_W-1:0]  cfg_cnt_i;
  logic [AP_W-1:0]   cfg_data_i;
  logic [CW_W-1:0]   cfg_cw_i;
  logic [LEN_W-1:0]  cfg_len_i;
  logic              sym_valid_i;
  logic              sym_ready_o;
  logic [CODE_W-1:0] sym_code_i;
  logic [SYM_W-1:0]  sym_data_i;
  logic              flush_i;
  logic              flush_done_o;
  logic              cw_valid_o;
  logic              cw_ready_i;
  logic [CW_W-1:0]   cw_data_o;
  logic [LEN_W-1:0]  cw_len_o;
  logic [CODE_W-1:0] cw_code_o;
  logic              cw_flush_o;
  logic              err_o;
  logic              busy_o;
`ifdef LE_CODEBOOK_STATS_EN
  logic [31:0]       stat_cw_cnt_o;
  logic [15:0]       stat_err_cnt_o;
`endif

  int tests_run  = 0;
  int tests_fail = 0;
  int hs_cnt     = 0;
  int err_cnt    = 0;
  int done_cnt   = 0;
  logic [CW_W-1:0]   last_cw;
  logic [LEN_W-1:0]  last_len;
  logic [CODE_W-1:0] last_code;
  logic              last_flush;

  lowentropy_codebook_engine dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_flush_i  (cfg_flush_i),
    .cfg_code_i   (cfg_code_i),
    .cfg_cnt_i    (cfg_cnt_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_cw_i     (cfg_cw_i),
    .cfg_len_i    (cfg_len_i),
    .sym_valid_i  (sym_valid_i),
    .sym_ready_o  (sym_ready_o),
    .sym_code_i   (sym_code_i),
    .sym_data_i   (sym_data_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .cw_valid_o   (cw_valid_o),
    .cw_ready_i   (cw_ready_i),
    .cw_data_o    (cw_data_o),
    .cw_len_o     (cw_len_o),
    .cw_code_o    (cw_code_o),
    .cw_flush_o   (cw_flush_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
`ifdef LE_CODEBOOK_STATS_EN
    ,
    .stat_cw_cnt_o  (stat_cw_cnt_o),
    .stat_err_cnt_o (stat_err_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Event monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk_i) begin
    if (rst_n_i && cw_valid_o && cw_ready_i) begin
      hs_cnt     = hs_cnt + 1;
      last_cw    = cw_data_o;
      last_len   = cw_len_o;
      last_code  = cw_code_o;
      last_flush = cw_flush_o;
      $display("[TB] cw handshake: data=%0h len=%0d code=%0d flush=%0b",
               cw_data_o, cw_len_o, cw_code_o, cw_flush_o);
    end
    if (rst_n_i && err_o) err_cnt = err_cnt + 1;
    if (rst_n_i && flush_done_o) done_cnt = done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic fl, input logic [CODE_W-1:0] c,
                           input logic [LEN_W-1:0] n, input logic [AP_W-1:0] d,
                           input logic [CW_W-1:0] w, input logic [LEN_W-1:0] l);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_valid_i = 1'b1; cfg_flush_i = fl;
    cfg_code_i = c; cfg_cnt_i = n; cfg_data_i = d; cfg_cw_i = w; cfg_len_i = l;
    step();
    cfg_we_i = 1'b0;
  endtask

  // Present one symbol; returns in the cycle after acceptance (the MATCH cycle).
  task automatic send_sym(input logic [CODE_W-1:0] c, input logic [SYM_W-1:0] s);
    int k;
    k = 0;
    while (!sym_ready_o && k < 50) begin
      step();
      k++;
    end
    if (!sym_ready_o) chk("sym_ready_wait", {63'd0, sym_ready_o}, 64'd1);
    sym_valid_i = 1'b1; sym_code_i = c; sym_data_i = s;
    step();
    sym_valid_i = 1'b0;
  endtask

  // Expect a codeword two cycles after acceptance; consumes it if cw_ready_i is high.
  task automatic expect_hit(input string tag, input logic [CW_W-1:0] w, input logic [LEN_W-1:0] l,
                            input logic [CODE_W-1:0] c);
    chk({tag, "_t1_valid"}, {63'd0, cw_valid_o}, 64'd0);
    step();
    chk({tag, "_t2_valid"}, {63'd0, cw_valid_o}, 64'd1);
    chk({tag, "_data"}, 64'(cw_data_o), 64'(w));
    chk({tag, "_len"}, 64'(cw_len_o), 64'(l));
    chk({tag, "_code"}, 64'(cw_code_o), 64'(c));
    chk({tag, "_flush"}, {63'd0, cw_flush_o}, 64'd0);
    if (cw_ready_i) step();
  endtask

  task automatic expect_miss(input string tag);
    int hs0;
    hs0 = hs_cnt;
    step();
    step();
    step();
    chk({tag, "_no_cw"}, 64'(hs_cnt), 64'(hs0));
    chk({tag, "_ready"}, {63'd0, sym_ready_o}, 64'd1);
  endtask

  initial begin
    int k, hs0, err0, done0;
    logic [SYM_W-1:0] esc;
    esc = ESC_SYM;
    rst_n_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_valid_i = 1'b0; cfg_flush_i = 1'b0;
    cfg_code_i = '0; cfg_cnt_i = '0; cfg_data_i = '0; cfg_cw_i = '0; cfg_len_i = '0;
    sym_valid_i = 1'b0; sym_code_i = '0; sym_data_i = '0; flush_i = 1'b0; cw_ready_i = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_sym_ready", {63'd0, sym_ready_o}, 64'd1);
    chk("rst_cw_valid", {63'd0, cw_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_done", {63'd0, flush_done_o}, 64'd0);
    chk("rst_cw_data", 64'(cw_data_o), 64'd0);
    rst_n_i = 1'b1;
    step();

    // Single-symbol code: F on code 7
    cfg_write(8'd0, 1'b0, 4'd7, 6'd1, 64'hF, 21'h3F6, 6'd10);
    send_sym(4'd7, esc);
    expect_hit("esc7", 21'h3F6, 6'd10, 4'd7);
    send_sym(4'd7, esc);
    expect_hit("esc7_again", 21'h3F6, 6'd10, 4'd7);

    // Two-symbol code: 1 then F on code 7
    cfg_write(8'd1, 1'b0, 4'd7, 6'd2, 64'h1F, 21'h1FF8, 6'd13);
    send_sym(4'd7, 4'h1);
    expect_miss("two_first");
    send_sym(4'd7, esc);
    expect_hit("two_second", 21'h1FF8, 6'd13, 4'd7);

    // Backpressure: hold cw_ready_i low for 5 cycles
    cw_ready_i = 1'b0;
    send_sym(4'd7, esc);
    expect_hit("hold", 21'h3F6, 6'd10, 4'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {63'd0, cw_valid_o}, 64'd1);
      chk("hold_data", 64'(cw_data_o), 64'h3F6);
      chk("hold_sym_ready", {63'd0, sym_ready_o}, 64'd0);
    end
    hs0 = hs_cnt;
    cw_ready_i = 1'b1;
    step();
    step();
    chk("hold_one_hs", 64'(hs_cnt), 64'(hs0 + 1));
    chk("hold_released", {63'd0, cw_valid_o}, 64'd0);

    // Overflow: 16 symbols of 1 on code 2 with no code 2 entries
    hs0 = hs_cnt; err0 = err_cnt;
    for (int i = 0; i < PREFIX_MAX; i++) send_sym(4'd2, 4'h1);
    step();
    step();
    chk("ovf_err_pulses", 64'(err_cnt), 64'(err0 + 1));
    chk("ovf_no_cw", 64'(hs_cnt), 64'(hs0));
    cfg_write(8'd2, 1'b0, 4'd2, 6'd1, 64'h1, 21'h2A, 6'd6);
    send_sym(4'd2, 4'h1);
    expect_hit("ovf_cleared", 21'h2A, 6'd6, 4'd2);

    // Flush: code 3 prefix 01 (has flush entry), code 9 prefix 2 (none)
    send_sym(4'd3, 4'h0);
    expect_miss("fl_pre3a");
    send_sym(4'd3, 4'h1);
    expect_miss("fl_pre3b");
    send_sym(4'd9, 4'h2);
    expect_miss("fl_pre9");
    cfg_write(8'd3, 1'b1, 4'd3, 6'd2, 64'h01, 21'h5, 6'd3);
    hs0 = hs_cnt; err0 = err_cnt; done0 = done_cnt;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    k = 1;
    while (!flush_done_o && k < 200) begin
      step();
      k++;
    end
    chk("fl_done_seen", {63'd0, flush_done_o}, 64'd1);
    step();
    chk("fl_one_cw", 64'(hs_cnt), 64'(hs0 + 1));
    chk("fl_cw_data", 64'(last_cw), 64'h5);
    chk("fl_cw_len", 64'(last_len), 64'd3);
    chk("fl_cw_code", 64'(last_code), 64'd3);
    chk("fl_cw_flag", {63'd0, last_flush}, 64'd1);
    chk("fl_one_err", 64'(err_cnt), 64'(err0 + 1));
    chk("fl_one_done", 64'(done_cnt), 64'(done0 + 1));

    // Second flush with all prefixes empty: minimum latency, flush beats a symbol
    hs0 = hs_cnt; err0 = err_cnt;
    flush_i = 1'b1;
    sym_valid_i = 1'b1; sym_code_i = 4'd7; sym_data_i = esc;
    #1;
    chk("fl2_sym_ready_low", {63'd0, sym_ready_o}, 64'd0);
    step();
    flush_i = 1'b0;
    sym_valid_i = 1'b0;
    k = 1;
    while (!flush_done_o && k < 200) begin
      step();
      k++;
    end
    chk("fl2_latency", 64'(k), 64'(NUM_CODES + 1));
    step();
    chk("fl2_no_cw", 64'(hs_cnt), 64'(hs0));
    chk("fl2_no_err", 64'(err_cnt), 64'(err0));

    // Table write while busy is dropped
    cw_ready_i = 1'b0;
    send_sym(4'd7, esc);
    expect_hit("busywr", 21'h3F6, 6'd10, 4'd7);
    cfg_write(8'd5, 1'b0, 4'd4, 6'd1, 64'h3, 21'h11, 6'd5);
    cw_ready_i = 1'b1;
    step();
    send_sym(4'd4, 4'h3);
    expect_miss("busywr_dropped");

    // Reset during EMIT drops the codeword and invalidates the table
    cw_ready_i = 1'b0;
    send_sym(4'd7, esc);
    expect_hit("rst_emit", 21'h3F6, 6'd10, 4'd7);
    rst_n_i = 1'b0;
    step();
    chk("rst_emit_valid", {63'd0, cw_valid_o}, 64'd0);
    chk("rst_emit_busy", {63'd0, busy_o}, 64'd0);
    rst_n_i = 1'b1;
    cw_ready_i = 1'b1;
    step();
    send_sym(4'd7, esc);
    expect_miss("rst_table_invalid");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule

// File: doc/lowentropy_codebook_engine.md
# lowentropy_codebook_engine

Parametrised, table-driven low-entropy code engine for the CCSDS-123.0-B-2 hybrid entropy coder. It keeps one active prefix per low-entropy code and appends incoming symbols to it. When a prefix matches a complete input codeword in a runtime-programmable codebook table, the engine emits the output codeword with its length. On request it flushes every non-empty prefix using the table's flush codewords. It sits between the code-selection logic and the bit packer, and replaces the fixed per-code combinational codebooks.

## Interface
- NUM_CODES, 16, number of low-entropy codes (active prefixes)
- SYM_W, 4, symbol width in bits; the value 'hF is the escape symbol
- PREFIX_MAX, 16, maximum prefix length in symbols; prefix data width AP_W = PREFIX_MAX*SYM_W = 64
- CW_W, 21, output codeword width
- LEN_W, 6, codeword-length and prefix-count width
- TABLE_DEPTH, 256, number of codebook entries
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- cfg_we_i  in  1  table write strobe
- cfg_addr_i  in  clog2(TABLE_DEPTH)  entry index
- cfg_valid_i / cfg_flush_i  in  1 / 1  entry valid; entry is a flush codeword
- cfg_code_i  in  clog2(NUM_CODES)  code index of the entry
- cfg_cnt_i / cfg_data_i  in  LEN_W / AP_W  match key: prefix count and data
- cfg_cw_i / cfg_len_i  in  CW_W / LEN_W  codeword (right-aligned) and its length
- sym_valid_i / sym_ready_o  in / out  1 / 1  symbol handshake
- sym_code_i / sym_data_i  in  clog2(NUM_CODES) / SYM_W  target code and symbol
- flush_i  in  1  flush request, pulse
- flush_done_o  out  1  one-cycle pulse when the flush completes
- cw_valid_o / cw_ready_i  out / in  1 / 1  codeword handshake
- cw_data_o / cw_len_o / cw_code_o / cw_flush_o  out  CW_W / LEN_W / clog2(NUM_CODES) / 1  codeword, length, source code, flush flag
- err_o  out  1  one-cycle pulse: prefix overflow, or a non-empty prefix with no flush entry
- busy_o  out  1  high whenever the FSM is not IDLE

## Operation
- State per code: ap_cnt (LEN_W bits) and ap_data (AP_W bits). Appending a symbol computes ap_data' = {ap_data[AP_W-SYM_W-1:0], sym} and ap_cnt' = ap_cnt+1. The newest symbol is in the LSBs; for example, symbols 1, 0, F give data 'h10F with count 3.
- An entry matches when it is valid, its flush bit equals the mode (0 for symbols, 1 for flush), and its code, count and full AP_W data are all equal to the key. If several entries match, the lowest index wins.
- FSM states: IDLE, MATCH, EMIT, FSCAN, FMATCH, FEMIT.
- IDLE: if flush_i is high, go to FSCAN with the scan index set to 0. Otherwise, on a symbol handshake, latch the key (code, ap_cnt', ap_data') and go to MATCH.
- sym_ready_o = (state==IDLE) & !flush_i. flush_i takes priority over a symbol in the same cycle.
- MATCH:
  - hit: load the cw registers, clear that code's prefix, go to EMIT.
  - miss with ap_cnt' < PREFIX_MAX: store the extended prefix, go to IDLE.
  - miss with ap_cnt' == PREFIX_MAX: pulse err_o, clear the prefix, go to IDLE.
- EMIT: cw_valid_o is high. When cw_ready_i is high, go to IDLE.
- FSCAN: if the prefix at the scan index is empty, advance the index. If it is non-empty, latch it as the key and go to FMATCH. After index NUM_CODES-1, pulse flush_done_o and go to IDLE.
- FMATCH: the prefix is cleared whether or not it matches.
  - hit: go to FEMIT with cw_flush_o=1.
  - miss: pulse err_o and continue in FSCAN.
- FEMIT: on the cw handshake, advance the index and return to FSCAN.
- Table writes are honoured only when busy_o=0; a write while busy is silently dropped.
- cw_data_o, cw_len_o, cw_code_o and cw_flush_o stay stable while cw_valid_o=1 and cw_ready_i=0.

## Timing
- Reset: state IDLE, all ap_cnt=0, every table entry marked invalid. All outputs are 0 except sym_ready_o, which is 1. Table data fields are not reset.
- Latency: a symbol accepted in cycle T gives cw_valid_o in T+2 on a hit.
- Throughput: one symbol per 2 cycles on a miss; 3 cycles or more per symbol on a hit.
- Flush: one cycle per empty code; 3 cycles or more per non-empty code. Minimum flush_done_o latency is NUM_CODES+1 cycles after flush_i.
- Reset in any state, including during EMIT/FEMIT or mid-scan: in the next cycle cw_valid_o=0 and all prefixes are empty. The pending codeword is dropped.

## Configuration
- LE_CODEBOOK_STATS_EN defined: adds two ports.
  - stat_cw_cnt_o out, 32 bits: counts cw handshakes, wraps around.
  - stat_err_cnt_o out, 16 bits: counts err_o pulses, saturates.
  - Both counters are reset by rst_n_i.
- Not defined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Package lowentropy_codebook_pkg contains: the FSM state enum; a codebook-entry struct (valid, flush, code, cnt, data, cw, len); the localparams AP_W and CODE_W = clog2(NUM_CODES); and ESC_SYM='hF.
- Sub-module codebook_cam_match: a combinational parallel compare over TABLE_DEPTH entries plus a lowest-index priority encoder. Outputs are hit, cw and len.

## Test plan
- Program entry 0 = {code 7, cnt 1, data 'hF, cw 'b1111110110, len 10}; send symbol F on code 7 -> cw_valid_o at T+2 with data 0x3F6, len 10, cw_code_o 7, flush 0; code 7 prefix is then empty.
- Program {code 7, cnt 2, data 'h1F, len 13, cw 0x1FF8}; send 1, then F -> no codeword after the first symbol; the second gives cw 0x1FF8, len 13.
- Hold cw_ready_i low for 5 cycles during EMIT -> cw outputs are stable and sym_ready_o stays 0; exactly one handshake occurs.
- Empty table, send 16 symbols of 1 on code 2 -> a single err_o pulse in the 16th MATCH cycle, no codeword, and code 2 cnt = 0.
- Code 3 prefix 'h01 (count 2) with flush entry cw 0x5 len 3, code 9 prefix 'h2 with no flush entry, pulse flush_i -> one codeword {0x5, 3, code 3, flush 1}, one err_o pulse, flush_done_o once, all prefixes empty.
- Assert rst_n_i during EMIT -> next cycle cw_valid_o=0 and a previously valid entry no longer matches (the symbol gives no output).
